apb_timer: RTL and testbench

- 8-bit prescaled timer/compare peripheral; an APB slave on the same bus the I2C-to-APB bridge drives, downstream of the bridge, alongside the debugger slave.
- Gives host software (over I2C) a periodic or one-shot event plus an interrupt line routable to a spare uio pin.
- Can freeze while the debugger reports the core halted, so time-based tests stay coherent across breakpoints.

---
 rtl/apb_timer_pkg.sv | 26 ++
 rtl/apb_timer_if.sv | 28 ++
 rtl/apb_wait_fsm.sv | 66 ++++++
 rtl/apb_timer.sv | 168 ++++++++++++++++
 tb/tb_apb_timer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: shared definitions for the APB timer slave.
//   - register address map
//   - CTRL / STATUS bit positions
//   - APB handshake state enum (also usable by other 1-wait-state slaves)
package apb_timer_pkg;

  localparam int unsigned ADDR_CTRL     = 32'h00;
  localparam int unsigned ADDR_PRESCALE = 32'h01;
  localparam int unsigned ADDR_COMPARE  = 32'h02;
  localparam int unsigned ADDR_COUNT    = 32'h03;
  localparam int unsigned ADDR_STATUS   = 32'h04;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_IRQEN      = 2;
  localparam int CTRL_FREEZE     = 3;

  localparam int STATUS_MATCH = 0;

  typedef enum logic [1:0] {
    APB_IDLE = 2'd0,
    APB_WAIT = 2'd1,
    APB_DONE = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_timer_if.sv
// apb_timer_if: APB bus bundle between the I2C-to-APB bridge (master) and
// its slaves.
//   PSEL, PADDR, PENABLE, PWRITE, PWDATA : master -> slave
//   PRDATA, PREADY                       : slave -> master
// ADDR_W must match the ADDR_W of the slave it is connected to.
interface apb_timer_if #(
  parameter int ADDR_W = 5
);

  logic              PSEL;
  logic [ADDR_W-1:0] PADDR;
  logic              PENABLE;
  logic              PWRITE;
  logic [7:0]        PWDATA;
  logic [7:0]        PRDATA;
  logic              PREADY;

  modport master (
    output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/apb_wait_fsm.sv
// apb_wait_fsm: generic APB slave handshake with exactly one wait state.
//   clk, rst        : clock, asynchronous active-high reset
//   psel, penable   : APB select / access phase
//   pwrite          : APB direction
//   access_rd       : 1-cycle strobe in the wait cycle of a read (load PRDATA)
//   access_wr       : 1-cycle strobe in the done cycle of a write (commit at
//                     the end of that cycle)
//   pready          : APB PREADY, high for exactly one cycle per transfer
//
// state | meaning
// IDLE  | no transfer in progress, PREADY=0
// WAIT  | first access-phase cycle, PREADY=0, read data is captured
// DONE  | second access-phase cycle, PREADY=1, write commits at its end
module apb_wait_fsm
  import apb_timer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  output logic access_rd,
  output logic access_wr,
  output logic pready
);

  localparam logic [1:0] S_IDLE = 2'(APB_IDLE);
  localparam logic [1:0] S_WAIT = 2'(APB_WAIT);
  localparam logic [1:0] S_DONE = 2'(APB_DONE);

  logic [1:0] state_q;
  logic [1:0] state_cur;
  logic [1:0] state_d;

  // The wait state is the first access-phase cycle itself: IDLE seeing
  // PSEL & PENABLE is already in WAIT, which keeps the access phase at
  // two cycles (one PREADY=0, one PREADY=1).
  always_comb begin
    state_cur = state_q;
    if (state_q == S_IDLE && psel && penable) begin
      state_cur = S_WAIT;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_cur)
      S_WAIT:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign access_rd = (state_cur == S_WAIT) && !pwrite;
  // A master that drops PSEL during DONE gets no write committed.
  assign access_wr = (state_q == S_DONE) && psel && pwrite;
  assign pready    = (state_q == S_DONE);

endmodule

// File: rtl/apb_timer.sv
// apb_timer: 8-bit prescaled timer/compare APB slave.
//   PCLK, PRESET : clock, asynchronous active-high reset
//   apb          : APB slave port (PSEL/PADDR/PENABLE/PWRITE/PWDATA in,
//                  PRDATA/PREADY out), one wait state per transfer
//   HALTED       : debugger halt status, synchronous to PCLK
//   IRQ          : level interrupt, MATCH & IRQEN
// Registers: 0x00 CTRL {FREEZE,IRQEN,AUTORELOAD,EN}, 0x01 PRESCALE,
//            0x02 COMPARE, 0x03 COUNT, 0x04 STATUS {MATCH} (write-1-to-clear).
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int         ADDR_W       = 5,
  parameter logic [7:0] PRESCALE_RST = 8'd0
) (
  input  logic       PCLK,
  input  logic       PRESET,
  apb_timer_if.slave apb,
  input  logic       HALTED,
  output logic       IRQ
);

  logic       access_rd;
  logic       access_wr;
  logic       pready;

  logic       ctrl_en;
  logic       ctrl_autoreload;
  logic       ctrl_irqen;
  logic       ctrl_freeze;
  logic [7:0] prescale_q;
  logic [7:0] compare_q;
  logic [7:0] count_q;
  logic [7:0] psc_q;
  logic       match_q;
  logic [7:0] prdata_q;
  logic [7:0] rdata_mux;

  logic       wr_ctrl;
  logic       wr_prescale;
  logic       wr_compare;
  logic       wr_count;
  logic       wr_status;
  logic       run;
  logic       tick;
  logic       hit;
  logic       restart;

  apb_wait_fsm u_fsm (
    .clk       (PCLK),
    .rst       (PRESET),
    .psel      (apb.PSEL),
    .penable   (apb.PENABLE),
    .pwrite    (apb.PWRITE),
    .access_rd (access_rd),
    .access_wr (access_wr),
    .pready    (pready)
  );

  assign wr_ctrl     = access_wr && (apb.PADDR == ADDR_W'(ADDR_CTRL));
  assign wr_prescale = access_wr && (apb.PADDR == ADDR_W'(ADDR_PRESCALE));
  assign wr_compare  = access_wr && (apb.PADDR == ADDR_W'(ADDR_COMPARE));
  assign wr_count    = access_wr && (apb.PADDR == ADDR_W'(ADDR_COUNT));
  assign wr_status   = access_wr && (apb.PADDR == ADDR_W'(ADDR_STATUS));

  assign run  = ctrl_en && !(ctrl_freeze && HALTED);
  assign tick = run && (psc_q == prescale_q);
  assign hit  = (count_q == compare_q);

  // Restarting on PRESCALE/COUNT writes and on enable keeps the first
  // period after reconfiguration a full PRESCALE+1 cycles.
  assign restart = wr_prescale || wr_count ||
                   (wr_ctrl && apb.PWDATA[CTRL_EN] && !ctrl_en);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      psc_q <= 8'd0;
    end else if (restart) begin
      psc_q <= 8'd0;
    end else if (run) begin
      psc_q <= tick ? 8'd0 : psc_q + 8'd1;
    end
  end

  // A CTRL write in the same cycle as a one-shot match wins over the
  // automatic EN clear.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl_en         <= 1'b0;
      ctrl_autoreload <= 1'b0;
      ctrl_irqen      <= 1'b0;
      ctrl_freeze     <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en         <= apb.PWDATA[CTRL_EN];
      ctrl_autoreload <= apb.PWDATA[CTRL_AUTORELOAD];
      ctrl_irqen      <= apb.PWDATA[CTRL_IRQEN];
      ctrl_freeze     <= apb.PWDATA[CTRL_FREEZE];
    end else if (tick && hit && !ctrl_autoreload) begin
      ctrl_en <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      count_q <= 8'd0;
    end else if (wr_count) begin
      count_q <= apb.PWDATA;
    end else if (tick) begin
      if (hit) begin
        if (ctrl_autoreload) begin
          count_q <= 8'd0;
        end
      end else begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  // Setting has priority over write-1-to-clear so a match is never lost.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      match_q <= 1'b0;
    end else if (tick && hit) begin
      match_q <= 1'b1;
    end else if (wr_status && apb.PWDATA[STATUS_MATCH]) begin
      match_q <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      prescale_q <= PRESCALE_RST;
      compare_q  <= 8'hFF;
    end else begin
      if (wr_prescale) begin
        prescale_q <= apb.PWDATA;
      end
      if (wr_compare) begin
        compare_q <= apb.PWDATA;
      end
    end
  end

  always_comb begin
    rdata_mux = 8'h00;
    case (apb.PADDR)
      ADDR_W'(ADDR_CTRL):     rdata_mux = {4'b0000, ctrl_freeze, ctrl_irqen,
                                           ctrl_autoreload, ctrl_en};
      ADDR_W'(ADDR_PRESCALE): rdata_mux = prescale_q;
      ADDR_W'(ADDR_COMPARE):  rdata_mux = compare_q;
      ADDR_W'(ADDR_COUNT):    rdata_mux = count_q;
      ADDR_W'(ADDR_STATUS):   rdata_mux = {7'b0000000, match_q};
      default:                rdata_mux = 8'h00;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      prdata_q <= 8'h00;
    end else if (access_rd) begin
      prdata_q <= rdata_mux;
    end
  end

  assign apb.PRDATA = prdata_q;
  assign apb.PREADY = pready;
  assign IRQ        = match_q && ctrl_irqen;

endmodule

// File: tb/tb_apb_timer.sv
module tb_apb_timer;

  localparam logic [4:0] A_CTRL = 5'h00;
  localparam logic [4:0] A_PRE  = 5'h01;
  localparam logic [4:0] A_CMP  = 5'h02;
  localparam logic [4:0] A_CNT  = 5'h03;
  localparam logic [4:0] A_STA  = 5'h04;
  localparam logic [4:0] A_UNM  = 5'h1F;

  logic PCLK;
  logic PRESET;
  logic HALTED;
  logic IRQ;
  int   cyc;
  int   errors;
  int   checks;

  apb_timer_if #(.ADDR_W(5)) apb ();

  apb_timer #(.ADDR_W(5), .PRESCALE_RST(8'd0)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .apb    (apb.slave),
    .HALTED (HALTED),
    .IRQ    (IRQ)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
    logic       irq;
  } vec_t;

  vec_t vt [27];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [4:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output int nwait, output logic rdy_after);
    logic done;
    done  = 1'b0;
    rd    = 8'h00;
    nwait = 0;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PADDR = a; apb.PWRITE = wr; apb.PWDATA = d; apb.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    for (int n = 0; n < 8 && !done; n++) begin
      @(negedge PCLK);
      if (apb.PREADY === 1'b1) begin
        rd   = apb.PRDATA;
        done = 1'b1;
      end else begin
        nwait++;
      end
    end
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    rdy_after = apb.PREADY;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout addr=0x%0h: PREADY never rose, required 1", a);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    logic [7:0] r;
    int         nw;
    logic       ra;
    xfer(1'b1, a, d, r, nw, ra);
    chk("wr_wait_states", nw, 1);
  endtask

  task automatic rdchk(input string nm, input logic [4:0] a, input logic [7:0] exp);
    logic [7:0] r;
    int         nw;
    logic       ra;
    xfer(1'b0, a, 8'h00, r, nw, ra);
    chk(nm, r, exp);
  endtask

  task automatic wait_irq(input int budget, output logic seen);
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge PCLK);
      if (IRQ === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] rd;
    int         nw;
    logic       ra;
    logic       seen;
    int         t_en;

    errors = 0;
    checks = 0;
    PRESET = 1'b1;
    HALTED = 1'b0;
    apb.PSEL = 1'b0; apb.PADDR = 5'h00; apb.PENABLE = 1'b0;
    apb.PWRITE = 1'b0; apb.PWDATA = 8'h00;

    vt[0]  = '{1'b0, A_CTRL, 8'h00, 8'h00, 1'b0};
    vt[1]  = '{1'b0, A_PRE,  8'h00, 8'h00, 1'b0};
    vt[2]  = '{1'b0, A_CMP,  8'h00, 8'hFF, 1'b0};
    vt[3]  = '{1'b0, A_CNT,  8'h00, 8'h00, 1'b0};
    vt[4]  = '{1'b0, A_STA,  8'h00, 8'h00, 1'b0};
    vt[5]  = '{1'b1, A_UNM,  8'hAA, 8'h00, 1'b0};
    vt[6]  = '{1'b0, A_UNM,  8'h00, 8'h00, 1'b0};
    vt[7]  = '{1'b1, A_PRE,  8'h5A, 8'h00, 1'b0};
    vt[8]  = '{1'b0, A_PRE,  8'h00, 8'h5A, 1'b0};
    vt[9]  = '{1'b1, A_CTRL, 8'hFE, 8'h00, 1'b0};
    vt[10] = '{1'b0, A_CTRL, 8'h00, 8'h0E, 1'b0};
    vt[11] = '{1'b1, A_CTRL, 8'h00, 8'h00, 1'b0};
    vt[12] = '{1'b1, A_CMP,  8'h33, 8'h00, 1'b0};
    vt[13] = '{1'b0, A_CMP,  8'h00, 8'h33, 1'b0};
    vt[14] = '{1'b1, A_CNT,  8'h77, 8'h00, 1'b0};
    vt[15] = '{1'b0, A_CNT,  8'h00, 8'h77, 1'b0};
    vt[16] = '{1'b1, A_CNT,  8'h00, 8'h00, 1'b0};
    vt[17] = '{1'b1, A_PRE,  8'h00, 8'h00, 1'b0};
    vt[18] = '{1'b1, A_CMP,  8'h02, 8'h00, 1'b0};
    vt[19] = '{1'b1, A_CTRL, 8'h05, 8'h00, 1'b0};
    vt[20] = '{1'b0, A_PRE,  8'h00, 8'h00, 1'b1};
    vt[21] = '{1'b0, A_STA,  8'h00, 8'h01, 1'b1};
    vt[22] = '{1'b0, A_CTRL, 8'h00, 8'h04, 1'b1};
    vt[23] = '{1'b0, A_CNT,  8'h00, 8'h02, 1'b1};
    vt[24] = '{1'b1, A_STA,  8'h01, 8'h00, 1'b0};
    vt[25] = '{1'b0, A_STA,  8'h00, 8'h00, 1'b0};
    vt[26] = '{1'b1, A_CTRL, 8'h00, 8'h00, 1'b0};

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("reset_pready", apb.PREADY, 1'b0);
    chk("reset_irq", IRQ, 1'b0);
    chk("reset_prdata", apb.PRDATA, 8'h00);
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    // Register map, handshake, unmapped address, one-shot
    for (int i = 0; i < 27; i++) begin
      xfer(vt[i].wr, vt[i].addr, vt[i].wdata, rd, nw, ra);
      chk($sformatf("vec%0d_wait_states", i), nw, 1);
      chk($sformatf("vec%0d_pready_after", i), ra, 1'b0);
      if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
      chk($sformatf("vec%0d_irq", i), IRQ, vt[i].irq);
    end

    // Periodic: 6 ticks of 4 cycles per match
    wr(A_PRE, 8'h03);
    wr(A_CMP, 8'h05);
    wr(A_CNT, 8'h00);
    wr(A_CTRL, 8'h07);
    t_en = cyc;
    wait_irq(60, seen);
    chk("per_irq1_seen", seen, 1'b1);
    chk("per_irq1_delay", cyc - t_en, 24);
    rdchk("per_count_wrapped", A_CNT, 8'h00);
    wr(A_STA, 8'h01);
    chk("per_irq_cleared", IRQ, 1'b0);
    wait_irq(60, seen);
    chk("per_irq2_seen", seen, 1'b1);
    chk("per_irq2_delay", cyc - t_en, 48);
    wr(A_CTRL, 8'h00);
    wr(A_STA, 8'h01);

    // Freeze while halted, then keep running without FREEZE
    wr(A_PRE, 8'h02);
    wr(A_CMP, 8'hFF);
    wr(A_CNT, 8'h00);
    HALTED = 1'b1;
    wr(A_CTRL, 8'h0B);
    repeat (10) @(posedge PCLK);
    rdchk("frz_count_held", A_CNT, 8'h00);
    wr(A_CTRL, 8'h03);
    repeat (6) @(posedge PCLK);
    rdchk("frz_off_count", A_CNT, 8'h02);
    HALTED = 1'b0;
    wr(A_CTRL, 8'h00);

    // W1C committed on a match tick: match every 4 cycles from enable
    wr(A_PRE, 8'h00);
    wr(A_CMP, 8'h03);
    wr(A_CNT, 8'h00);
    wr(A_STA, 8'h01);
    wr(A_CTRL, 8'h03);
    repeat (4) @(posedge PCLK);
    wr(A_STA, 8'h01);
    rdchk("col_w1c_match_kept", A_STA, 8'h01);

    // COUNT write on a tick cycle, then freeze to hold the value
    wr(A_CTRL, 8'h00);
    wr(A_CMP, 8'hFF);
    wr(A_CTRL, 8'h0D);
    chk("col_irq_pre", IRQ, 1'b1);
    wr(A_CNT, 8'h10);
    HALTED = 1'b1;
    rdchk("col_count_write_wins", A_CNT, 8'h10);

    // Reset in the middle of a transfer
    wr(A_CNT, 8'h42);
    rdchk("rst_pre_count", A_CNT, 8'h42);
    chk("rst_pre_irq", IRQ, 1'b1);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PADDR = A_CNT; apb.PWRITE = 1'b0; apb.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    #2;
    chk("rst_mid_pready", apb.PREADY, 1'b0);
    chk("rst_mid_irq", IRQ, 1'b0);
    chk("rst_mid_prdata", apb.PRDATA, 8'h00);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    HALTED = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    rdchk("rst_count", A_CNT, 8'h00);
    rdchk("rst_compare", A_CMP, 8'hFF);
    rdchk("rst_ctrl", A_CTRL, 8'h00);
    rdchk("rst_status", A_STA, 8'h00);
    chk("rst_irq_after", IRQ, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
